// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants for the BCD up/down counter: digit width, default digit
// ceiling, direction encodings and the illegal-digit clamp helper.
package bcd_pkg;

    localparam int DIGIT_WIDTH       = 4;
    localparam int DEFAULT_DIGIT_MAX = 9;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [DIGIT_WIDTH-1:0] clampDigit(
        input logic [DIGIT_WIDTH-1:0] value,
        input logic [DIGIT_WIDTH-1:0] ceiling
    );
        return (value > ceiling) ? ceiling : value;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle of the BCD up/down counter.
// The master drives count/load requests; the slave returns count, carry and load error.
interface bcd_updown_counter_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
);

    logic                          enable;
    logic                          load;
    logic                          up_down;
    logic [DIGIT_WIDTH*DIGITS-1:0] din;
    logic [DIGIT_WIDTH*DIGITS-1:0] dout;
    logic                          cout;
    logic                          load_err;

    modport master (
        output enable, load, up_down, din,
        input  dout, cout, load_err
    );

    modport slave (
        input  enable, load, up_down, din,
        output dout, cout, load_err
    );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD decade: wraps between 0 and DIGIT_MAX, emits carry/borrow co.
// Latency 1 cycle for load/count; co and err are combinational.
module bcd_digit
    import bcd_pkg::*;
#(
    parameter int DIGIT_MAX = DEFAULT_DIGIT_MAX
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ci,
    input  logic                   up_down,
    input  logic                   load,
    input  logic [DIGIT_WIDTH-1:0] dinDigit,
    output logic [DIGIT_WIDTH-1:0] digit,
    output logic                   co,
    output logic                   err
);

    localparam logic [DIGIT_WIDTH-1:0] MAX_DIGIT = DIGIT_WIDTH'(DIGIT_MAX);

    logic atTerminal;

    // Terminal depends on direction so the same edge both wraps and ripples.
    assign atTerminal = (up_down == DIR_UP) ? (digit == MAX_DIGIT) : (digit == '0);
    assign co         = ci & atTerminal;
    assign err        = load & (dinDigit > MAX_DIGIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= clampDigit(dinDigit, MAX_DIGIT);
        end else if (ci) begin
            if (up_down == DIR_UP) begin
                digit <= atTerminal ? '0 : digit + 4'd1;
            end else begin
                digit <= atTerminal ? MAX_DIGIT : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-decade BCD up/down counter with clamped parallel load.
// Latency 1 cycle load/count to dout; cout is combinational; no backpressure.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int DIGIT_MAX = DEFAULT_DIGIT_MAX
) (
    input  logic                 clock,
    input  logic                 reset,
    bcd_updown_counter_if.slave  bus
);

    logic [DIGITS:0]   carryChain;
    logic [DIGITS-1:0] digitErr;
    logic              loadErrQ;

    // Load outranks counting, so a load edge never injects a carry.
    assign carryChain[0] = bus.enable & ~bus.load;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit #(
            .DIGIT_MAX (DIGIT_MAX)
        ) u_digit (
            .clock    (clock),
            .reset    (reset),
            .ci       (carryChain[k]),
            .up_down  (bus.up_down),
            .load     (bus.load),
            .dinDigit (bus.din[k*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .digit    (bus.dout[k*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .co       (carryChain[k+1]),
            .err      (digitErr[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            loadErrQ <= 1'b0;
        end else begin
            loadErrQ <= |digitErr;
        end
    end

    assign bus.load_err = loadErrQ;
    assign bus.cout     = carryChain[DIGITS];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for the 2-digit decimal BCD up/down counter.
module tb_bcd_updown_counter;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    bcd_updown_counter_if #(.DIGITS(2)) bus ();

    bcd_updown_counter #(
        .DIGITS    (2),
        .DIGIT_MAX (9)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] toBcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic test_reset();
        reset = 1'b1; bus.enable = 1'b1; bus.load = 1'b1; bus.up_down = 1'b1; bus.din = 8'hC5;
        tick();
        tick();
        checks++;
        if (bus.dout !== 8'h00) begin
            failures++; $display("FAIL reset_dout got=%h want=00", bus.dout);
        end
        checks++;
        if (bus.load_err !== 1'b0) begin
            failures++; $display("FAIL reset_load_err got=%b want=0", bus.load_err);
        end
        bus.load = 1'b0;
        #1;
        checks++;
        if (bus.cout !== 1'b0) begin
            failures++; $display("FAIL reset_cout got=%b want=0", bus.cout);
        end
    endtask

    task automatic test_count_up_full();
        reset = 1'b0; bus.enable = 1'b1; bus.load = 1'b0; bus.up_down = 1'b1; bus.din = 8'h00;
        #1;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (bus.dout !== toBcd(i)) begin
                failures++; $display("FAIL up_step_%0d got=%h want=%h", i, bus.dout, toBcd(i));
            end
            checks++;
            if (bus.cout !== (i == 99)) begin
                failures++; $display("FAIL up_cout_%0d got=%b want=%b", i, bus.cout, (i == 99));
            end
            tick();
        end
        checks++;
        if (bus.dout !== 8'h00) begin
            failures++; $display("FAIL up_wrap got=%h want=00", bus.dout);
        end
    endtask

    task automatic test_load_carry();
        logic [7:0] want [4];
        want = '{8'h07, 8'h08, 8'h09, 8'h10};
        bus.load = 1'b1; bus.din = 8'h07; bus.enable = 1'b1; bus.up_down = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.dout !== want[i]) begin
                failures++; $display("FAIL load_carry_%0d got=%h want=%h", i, bus.dout, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_down_wrap();
        bus.load = 1'b1; bus.din = 8'h00; bus.enable = 1'b1; bus.up_down = 1'b0;
        #1;
        checks++;
        if (bus.cout !== 1'b0) begin
            failures++; $display("FAIL cout_masked_by_load got=%b want=0", bus.cout);
        end
        tick();
        bus.load = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 8'h00 || bus.cout !== 1'b1) begin
            failures++; $display("FAIL down_at_00 got=%h/%b want=00/1", bus.dout, bus.cout);
        end
        tick();
        checks++;
        if (bus.dout !== 8'h99 || bus.cout !== 1'b0) begin
            failures++; $display("FAIL down_wrap got=%h/%b want=99/0", bus.dout, bus.cout);
        end
        tick();
        checks++;
        if (bus.dout !== 8'h98) begin
            failures++; $display("FAIL down_next got=%h want=98", bus.dout);
        end
    endtask

    task automatic test_load_clamp();
        logic [7:0] dinVec  [3];
        logic [7:0] wantVec [3];
        dinVec  = '{8'hC5, 8'h9F, 8'hFA};
        wantVec = '{8'h95, 8'h99, 8'h99};
        for (int i = 0; i < 3; i++) begin
            bus.load = 1'b1; bus.enable = 1'b0; bus.din = dinVec[i];
            tick();
            checks++;
            if (bus.dout !== wantVec[i] || bus.load_err !== 1'b1) begin
                failures++;
                $display("FAIL clamp_%h got=%h/%b want=%h/1", dinVec[i], bus.dout, bus.load_err, wantVec[i]);
            end
            bus.load = 1'b0;
            tick();
            checks++;
            if (bus.load_err !== 1'b0 || bus.dout !== wantVec[i]) begin
                failures++;
                $display("FAIL clamp_clear_%h got=%h/%b want=%h/0", dinVec[i], bus.dout, bus.load_err, wantVec[i]);
            end
        end
        bus.load = 1'b1; bus.din = 8'h58;
        tick();
        checks++;
        if (bus.dout !== 8'h58 || bus.load_err !== 1'b0) begin
            failures++; $display("FAIL legal_load got=%h/%b want=58/0", bus.dout, bus.load_err);
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset_override();
        bus.load = 1'b1; bus.din = 8'h42; bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.dout !== 8'h42) begin
            failures++; $display("FAIL preload_42 got=%h want=42", bus.dout);
        end
        reset = 1'b1; bus.load = 1'b1; bus.din = 8'hC7; bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.dout !== 8'h00 || bus.load_err !== 1'b0) begin
            failures++; $display("FAIL reset_override got=%h/%b want=00/0", bus.dout, bus.load_err);
        end
        reset = 1'b0; bus.load = 1'b0; bus.up_down = 1'b1; bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.dout !== 8'h01) begin
            failures++; $display("FAIL resume_after_reset got=%h want=01", bus.dout);
        end
    endtask

    task automatic test_hold_flip();
        for (int i = 0; i < 36; i++) tick();
        checks++;
        if (bus.dout !== 8'h37) begin
            failures++; $display("FAIL count_to_37 got=%h want=37", bus.dout);
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.cout !== 1'b0) begin
                failures++; $display("FAIL hold_cout_%0d got=%b want=0", i, bus.cout);
            end
            tick();
            checks++;
            if (bus.dout !== 8'h37) begin
                failures++; $display("FAIL hold_%0d got=%h want=37", i, bus.dout);
            end
        end
        bus.up_down = 1'b0; bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.dout !== 8'h36) begin
            failures++; $display("FAIL flip_down got=%h want=36", bus.dout);
        end
        bus.enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up_full();
        test_load_carry();
        test_down_wrap();
        test_load_clamp();
        test_reset_override();
        test_hold_flip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
